// File: rtl/s2c_pkg.sv
// Shared types and helpers for the s2c request arbiter: FSM states, ret codes
// and the round-robin next-grant search used by s2c_rr_arb.
package s2c_pkg;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        COLLECT,
        DELIVER
    } state_t;

    localparam logic [31:0] RET_OK           = 32'h0000_0000;
    localparam logic [31:0] RET_TIMEOUT_DFLT = 32'hFFFF_FFFF;
    localparam int          MAX_CH           = 16;

    typedef struct packed {
        logic       found;
        logic [3:0] idx;
    } rr_pick_t;

    // First requesting channel at or after ptr, wrapping at n_ch. Scanning from
    // the far end lets the closest hit overwrite earlier ones without a break.
    function automatic rr_pick_t rr_next_grant(
        input logic [MAX_CH-1:0] req,
        input logic [3:0]        ptr,
        input int                n_ch
    );
        rr_pick_t pick;
        int       c;
        pick = '0;
        for (int k = MAX_CH - 1; k >= 0; k--) begin
            if (k < n_ch) begin
                c = int'(ptr) + k;
                if (c >= n_ch) c = c - n_ch;
                if (req[c]) begin
                    pick.found = 1'b1;
                    pick.idx   = 4'(c);
                end
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/s2c_rr_arb.sv
// Combinational round-robin grant: picks the first requester at or after the
// priority pointer.
module s2c_rr_arb
    import s2c_pkg::*;
#(
    parameter int N_CH = 4,
    parameter int ID_W = 2
) (
    input  logic [N_CH-1:0] i_req,
    input  logic [ID_W-1:0] i_ptr,
    output logic            o_valid,
    output logic [ID_W-1:0] o_grant
);

    rr_pick_t w_pick;

    always_comb begin
        w_pick  = rr_next_grant(MAX_CH'(i_req), 4'(i_ptr), N_CH);
        o_valid = w_pick.found;
        o_grant = ID_W'(w_pick.idx);
    end

endmodule

// File: rtl/s2c_req_arb.sv
// Round-robin arbiter of N_CH get-data requesters onto one downstream port;
// buffers the downstream response and streams it back to the granted channel.
module s2c_req_arb
    import s2c_pkg::*;
#(
    parameter int          N_CH        = 4,
    parameter int          FN_W        = 32,
    parameter int          DATA_W      = 32,
    parameter int          DATA_SIZE   = 8,
    parameter int unsigned TIMEOUT     = 1024,
    parameter logic [31:0] RET_TIMEOUT = RET_TIMEOUT_DFLT,
    localparam int         ID_W        = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int         IDX_W       = (DATA_SIZE > 1) ? $clog2(DATA_SIZE) : 1
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_CH-1:0]    ch_req,
    input  logic [N_CH*FN_W-1:0] ch_fn,
    output logic [N_CH-1:0]    ch_done,
    output logic               up_valid,
    output logic [ID_W-1:0]    up_ch,
    output logic [IDX_W-1:0]   up_idx,
    output logic [DATA_W-1:0]  up_data,
    output logic [31:0]        up_ret,
    input  logic               up_ready,
    output logic               dn_valid,
    output logic [ID_W-1:0]    dn_id,
    output logic [FN_W-1:0]    dn_fn,
    input  logic               dn_ready,
    input  logic               dn_rsp_valid,
    input  logic [31:0]        dn_rsp_ret,
    input  logic [DATA_W-1:0]  dn_rsp_data,
    input  logic               dn_rsp_last
);

    localparam int CNT_W = $clog2(DATA_SIZE + 1);
    localparam int TMR_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

    state_t              r_state;
    logic [ID_W-1:0]     r_grant;
    logic [ID_W-1:0]     r_ptr;
    logic [FN_W-1:0]     r_fn;
    logic                r_dn_valid;
    logic [CNT_W-1:0]    r_cnt;
    logic [TMR_W-1:0]    r_timer;
    logic [31:0]         r_ret;
    logic [IDX_W-1:0]    r_idx;
    logic                r_up_valid;
    logic [N_CH-1:0]     r_done;
    logic [DATA_W-1:0]   r_buf [DATA_SIZE];

    logic                w_arb_valid;
    logic [ID_W-1:0]     w_arb_grant;
    logic [FN_W-1:0]     w_fn_sel;
    logic                w_room;
    logic [CNT_W-1:0]    w_cnt_next;
    logic [IDX_W-1:0]    w_wr_idx;
    logic                w_timeout;
    logic                w_rsp_end;

    s2c_rr_arb #(
        .N_CH (N_CH),
        .ID_W (ID_W)
    ) u_rr_arb (
        .i_req   (ch_req),
        .i_ptr   (r_ptr),
        .o_valid (w_arb_valid),
        .o_grant (w_arb_grant)
    );

    always_comb begin
        // NOTE: default first so the search loop can never leave w_fn_sel unassigned (no latch).
        w_fn_sel = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (w_arb_grant == ID_W'(c)) w_fn_sel = ch_fn[c*FN_W +: FN_W];
        end
    end

    assign w_room     = (r_cnt < CNT_W'(DATA_SIZE));
    assign w_cnt_next = w_room ? r_cnt + CNT_W'(1) : r_cnt;
    assign w_wr_idx   = IDX_W'(r_cnt);
    assign w_rsp_end  = dn_rsp_valid && dn_rsp_last;
    // Timer holds cycles already spent in COLLECT; +1 counts the current one.
    assign w_timeout  = (TIMEOUT != 0) && ((32'(r_timer) + 32'd1) >= TIMEOUT);

    // NOTE: the response buffer is deliberately not reset; r_cnt masks stale entries on read.
    always_ff @(posedge clk) begin
        if (r_state == COLLECT && dn_rsp_valid && w_room) begin
            r_buf[w_wr_idx] <= dn_rsp_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_grant    <= '0;
            r_ptr      <= '0;
            r_fn       <= '0;
            r_dn_valid <= 1'b0;
            r_cnt      <= '0;
            r_timer    <= '0;
            r_ret      <= RET_OK;
            r_idx      <= '0;
            r_up_valid <= 1'b0;
            r_done     <= '0;
        end else begin
            r_done <= '0;
            case (r_state)
                IDLE: begin
                    if (w_arb_valid) begin
                        r_grant    <= w_arb_grant;
                        r_fn       <= w_fn_sel;
                        r_dn_valid <= 1'b1;
                        r_state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (dn_ready) begin
                        r_dn_valid <= 1'b0;
                        r_cnt      <= '0;
                        r_timer    <= '0;
                        r_state    <= COLLECT;
                    end
                end
                COLLECT: begin
                    if (32'(r_timer) < TIMEOUT) r_timer <= r_timer + TMR_W'(1);
                    if (dn_rsp_valid) begin
                        r_cnt <= w_cnt_next;
                        if (r_cnt == '0) r_ret <= dn_rsp_ret;
                    end
                    if (w_rsp_end) begin
                        r_idx      <= '0;
                        r_up_valid <= 1'b1;
                        r_state    <= DELIVER;
                    end else if (w_timeout) begin
                        // Zero fill count makes every delivered word read as 0.
                        r_ret      <= RET_TIMEOUT;
                        r_cnt      <= '0;
                        r_idx      <= '0;
                        r_up_valid <= 1'b1;
                        r_state    <= DELIVER;
                    end
                end
                DELIVER: begin
                    if (up_ready) begin
                        if (r_idx == IDX_W'(DATA_SIZE - 1)) begin
                            r_up_valid <= 1'b0;
                            r_idx      <= '0;
                            r_done     <= N_CH'(1) << r_grant;
                            r_ptr      <= (r_grant == ID_W'(N_CH - 1)) ? '0 : r_grant + ID_W'(1);
                            r_state    <= IDLE;
                        end else begin
                            r_idx <= r_idx + IDX_W'(1);
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign ch_done  = r_done;
    assign dn_valid = r_dn_valid;
    assign dn_id    = r_grant;
    assign dn_fn    = r_fn;
    assign up_valid = r_up_valid;
    assign up_ch    = r_grant;
    assign up_idx   = r_idx;
    assign up_ret   = r_ret;
    assign up_data  = (32'(r_idx) < 32'(r_cnt)) ? r_buf[r_idx] : '0;

endmodule

// File: tb/tb_s2c_req_arb.sv
// Scoreboard bench for s2c_req_arb: directed cases from the test plan followed
// by randomized traffic, checked against an arbitration/response model.
module tb_s2c_req_arb;

    localparam int N_CH      = 4;
    localparam int FN_W      = 32;
    localparam int DATA_W    = 32;
    localparam int DATA_SIZE = 8;
    localparam int TIMEOUT   = 16;
    localparam int ID_W      = 2;
    localparam int IDX_W     = 3;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH-1:0]        ch_req;
    logic [N_CH*FN_W-1:0]   ch_fn;
    logic [N_CH-1:0]        ch_done;
    logic                   up_valid;
    logic [ID_W-1:0]        up_ch;
    logic [IDX_W-1:0]       up_idx;
    logic [DATA_W-1:0]      up_data;
    logic [31:0]            up_ret;
    logic                   up_ready = 1'b0;
    logic                   dn_valid;
    logic [ID_W-1:0]        dn_id;
    logic [FN_W-1:0]        dn_fn;
    logic                   dn_ready;
    logic                   dn_rsp_valid;
    logic [31:0]            dn_rsp_ret;
    logic [DATA_W-1:0]      dn_rsp_data;
    logic                   dn_rsp_last;

    s2c_req_arb #(
        .N_CH        (N_CH),
        .FN_W        (FN_W),
        .DATA_W      (DATA_W),
        .DATA_SIZE   (DATA_SIZE),
        .TIMEOUT     (TIMEOUT),
        .RET_TIMEOUT (32'hFFFF_FFFF)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ch_req       (ch_req),
        .ch_fn        (ch_fn),
        .ch_done      (ch_done),
        .up_valid     (up_valid),
        .up_ch        (up_ch),
        .up_idx       (up_idx),
        .up_data      (up_data),
        .up_ret       (up_ret),
        .up_ready     (up_ready),
        .dn_valid     (dn_valid),
        .dn_id        (dn_id),
        .dn_fn        (dn_fn),
        .dn_ready     (dn_ready),
        .dn_rsp_valid (dn_rsp_valid),
        .dn_rsp_ret   (dn_rsp_ret),
        .dn_rsp_data  (dn_rsp_data),
        .dn_rsp_last  (dn_rsp_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        int                ch;
        int                idx;
        logic [DATA_W-1:0] data;
        logic [31:0]       ret;
    } exp_t;

    exp_t              exp_q[$];
    int                n_checks = 0;
    int                n_fail   = 0;
    logic [N_CH-1:0]   req_v;
    logic [FN_W-1:0]   fn_v [N_CH];
    int                model_ptr;
    int                ur_mode = 0;
    int                ur_ph   = 0;

    assign ch_req = req_v;
    for (genvar c = 0; c < N_CH; c++) begin : g_fn
        assign ch_fn[c*FN_W +: FN_W] = fn_v[c];
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Arbitration rule: first requester at or after the priority pointer.
    function automatic int model_pick(input logic [N_CH-1:0] req, input int ptr);
        for (int k = 0; k < N_CH; k++) begin
            if (req[(ptr + k) % N_CH]) return (ptr + k) % N_CH;
        end
        return -1;
    endfunction

    always @(posedge clk) begin
        #1;
        ur_ph++;
        case (ur_mode)
            0:       up_ready = 1'b1;
            1:       up_ready = (ur_ph % 3 == 0);
            default: up_ready = ($urandom_range(0, 2) != 0);
        endcase
    end

    // Monitor: pops the scoreboard on every upstream handshake.
    logic [N_CH-1:0]   done_exp;
    logic              prev_stall;
    logic [ID_W-1:0]   p_ch;
    logic [IDX_W-1:0]  p_idx;
    logic [DATA_W-1:0] p_data;
    exp_t              m_e;

    always @(negedge clk) begin
        if (!rst_n) begin
            done_exp   = '0;
            prev_stall = 1'b0;
        end else begin
            if (done_exp != '0 || ch_done != '0) check("ch_done_pulse", 64'(ch_done), 64'(done_exp));
            done_exp = '0;
            if (prev_stall) begin
                check("up_hold", {up_valid, up_ch, up_idx, up_data}, {1'b1, p_ch, p_idx, p_data});
            end
            if (up_valid && up_ready) begin
                check("up_word_expected", 64'(exp_q.size() != 0), 64'd1);
                if (exp_q.size() != 0) begin
                    m_e = exp_q.pop_front();
                    check("up_ch", 64'(up_ch), 64'(m_e.ch));
                    check("up_idx", 64'(up_idx), 64'(m_e.idx));
                    check("up_data", 64'(up_data), 64'(m_e.data));
                    check("up_ret", 64'(up_ret), 64'(m_e.ret));
                    if (m_e.idx == DATA_SIZE - 1) done_exp = N_CH'(1) << m_e.ch;
                end
            end
            prev_stall = up_valid && !up_ready;
            p_ch       = up_ch;
            p_idx      = up_idx;
            p_data     = up_data;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_outputs_zero(input string name);
        check({name, "_ctl"}, 64'({ch_done, up_valid, up_ch, up_idx, dn_valid, dn_id}), 64'd0);
        check({name, "_data"}, {up_data, up_ret}, 64'd0);
        check({name, "_fn"}, 64'(dn_fn), 64'd0);
    endtask

    // One complete transaction as seen by the downstream agent.
    task automatic serve_one(input int len, input bit silent, input int stall,
                             input logic [DATA_W-1:0] base, input logic [31:0] ret,
                             input bit keep, output int id);
        int               n;
        int               exp_id;
        exp_t             e;
        logic [ID_W-1:0]  hold_id;
        logic [FN_W-1:0]  hold_fn;
        exp_id = model_pick(req_v, model_ptr);
        id = (exp_id < 0) ? 0 : exp_id;
        n = 0;
        while (!dn_valid && n < 50) begin
            tick();
            n++;
        end
        check("dn_valid_seen", 64'(dn_valid), 64'd1);
        check("dn_id", 64'(dn_id), 64'(exp_id));
        check("dn_fn", 64'(dn_fn), 64'(fn_v[id]));
        hold_id = dn_id;
        hold_fn = dn_fn;
        for (int s = 0; s < stall; s++) begin
            tick();
            check("dn_stall_hold", {dn_valid, dn_id, dn_fn}, {1'b1, hold_id, hold_fn});
        end
        dn_ready = 1'b1;
        tick();
        dn_ready = 1'b0;
        check("dn_valid_drop", 64'(dn_valid), 64'd0);
        for (int i = 0; i < DATA_SIZE; i++) begin
            e.ch   = id;
            e.idx  = i;
            e.data = (!silent && i < len) ? base + DATA_W'(i) : '0;
            e.ret  = silent ? 32'hFFFF_FFFF : ret;
            exp_q.push_back(e);
        end
        if (silent) begin
            n = 0;
            while (!up_valid && n < 100) begin
                tick();
                n++;
            end
            check("timeout_cycles", 64'(n), 64'(TIMEOUT));
            dn_rsp_valid = 1'b1;
            dn_rsp_data  = 32'hDEAD_BEEF;
            dn_rsp_ret   = 32'h1234_5678;
            dn_rsp_last  = 1'b1;
            tick();
            dn_rsp_valid = 1'b0;
            dn_rsp_last  = 1'b0;
        end else begin
            repeat ($urandom_range(0, 3)) tick();
            for (int i = 0; i < len; i++) begin
                dn_rsp_valid = 1'b1;
                dn_rsp_data  = base + DATA_W'(i);
                dn_rsp_ret   = (i == 0) ? ret : ~ret;
                dn_rsp_last  = (i == len - 1);
                tick();
            end
            dn_rsp_valid = 1'b0;
            dn_rsp_last  = 1'b0;
            check("rsp_to_up_latency", 64'(up_valid), 64'd1);
        end
        n = 0;
        while (!ch_done[id] && n < 300) begin
            tick();
            n++;
        end
        check("ch_done_seen", 64'(ch_done[id]), 64'd1);
        if (!keep) req_v[id] = 1'b0;
        model_ptr = (id + 1) % N_CH;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int id;
        int n;
        int rr_exp[5];
        rr_exp = '{0, 1, 2, 3, 0};
        rst_n        = 1'b0;
        req_v        = '0;
        for (int c = 0; c < N_CH; c++) fn_v[c] = '0;
        dn_ready     = 1'b0;
        dn_rsp_valid = 1'b0;
        dn_rsp_ret   = '0;
        dn_rsp_data  = '0;
        dn_rsp_last  = 1'b0;
        model_ptr    = 0;
        repeat (3) tick();
        check_outputs_zero("reset_state");
        rst_n = 1'b1;
        tick();
        check("idle_no_dn_valid", 64'(dn_valid), 64'd0);

        // Round-robin with every channel holding its request.
        for (int c = 0; c < N_CH; c++) fn_v[c] = 32'h100 + c;
        req_v = '1;
        for (int t = 0; t < 5; t++) begin
            serve_one(8, 1'b0, 0, $urandom, $urandom, 1'b1, id);
            check("rr_order", 64'(id), 64'(rr_exp[t]));
        end
        req_v = '0;

        // Single request on channel 1.
        fn_v[1]  = 32'h10;
        req_v[1] = 1'b1;
        tick();
        check("min_req_latency", 64'(dn_valid), 64'd1);
        serve_one(8, 1'b0, 0, 32'hA0, 32'h0, 1'b0, id);

        // Short then long response.
        req_v[1] = 1'b1;
        serve_one(3, 1'b0, 0, 32'h1, 32'h0, 1'b0, id);
        fn_v[2]  = 32'h22;
        req_v[2] = 1'b1;
        serve_one(10, 1'b0, 0, 32'h200, 32'h5, 1'b0, id);

        // Silent downstream.
        fn_v[3]  = 32'h33;
        req_v[3] = 1'b1;
        serve_one(0, 1'b1, 0, 32'h0, 32'h0, 1'b0, id);

        // Upstream and downstream backpressure.
        ur_mode  = 1;
        fn_v[0]  = 32'h44;
        req_v[0] = 1'b1;
        serve_one(8, 1'b0, 5, 32'h300, 32'h7, 1'b0, id);

        // Randomized traffic.
        ur_mode = 2;
        for (int t = 0; t < 40; t++) begin
            if (req_v == '0 || $urandom_range(0, 1) == 1) begin
                for (int c = 0; c < N_CH; c++) begin
                    if (!req_v[c] && $urandom_range(0, 1) == 1) begin
                        fn_v[c]  = $urandom;
                        req_v[c] = 1'b1;
                    end
                end
                if (req_v == '0) begin
                    n        = $urandom_range(0, N_CH - 1);
                    fn_v[n]  = $urandom;
                    req_v[n] = 1'b1;
                end
            end
            serve_one($urandom_range(1, 10), ($urandom_range(0, 7) == 0), $urandom_range(0, 3),
                      $urandom, $urandom, ($urandom_range(0, 3) == 0), id);
        end
        req_v   = '0;
        ur_mode = 0;
        repeat (2) tick();

        // Reset in the middle of COLLECT.
        req_v[1] = 1'b1;
        serve_one(8, 1'b0, 0, 32'h400, 32'h0, 1'b0, id);
        fn_v[3]  = 32'h77;
        req_v[3] = 1'b1;
        n = 0;
        while (!dn_valid && n < 50) begin
            tick();
            n++;
        end
        check("abort_dn_id", 64'(dn_id), 64'd3);
        dn_ready = 1'b1;
        tick();
        dn_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            dn_rsp_valid = 1'b1;
            dn_rsp_data  = 32'h500 + i;
            dn_rsp_ret   = 32'h9;
            dn_rsp_last  = 1'b0;
            tick();
        end
        rst_n = 1'b0;
        #1;
        check_outputs_zero("reset_mid_collect");
        dn_rsp_valid = 1'b0;
        req_v        = '0;
        repeat (2) tick();
        rst_n     = 1'b1;
        model_ptr = 0;
        fn_v[0]   = 32'h88;
        fn_v[2]   = 32'h99;
        req_v[0]  = 1'b1;
        req_v[2]  = 1'b1;
        serve_one(8, 1'b0, 0, 32'h600, 32'h0, 1'b0, id);
        check("post_reset_first_grant", 64'(id), 64'd0);
        serve_one(8, 1'b0, 0, 32'h700, 32'h3, 1'b0, id);
        check("post_reset_ch2_grant", 64'(id), 64'd2);

        repeat (5) tick();
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/s2c_req_arb.md
Name: s2c_req_arb

Overview:
- Synthesizable, parametrised successor to the single-lock get-data interface.
- Arbitrates N_CH independent requesters (IDs) onto one downstream get-data port, using round-robin instead of first-come blocking.
- Collects the downstream response (ret plus DATA_SIZE words) into a local buffer, then streams it back to the granted channel.
- Adds timeout and short/long-response handling. Sits between testbench/agent-side requesters and the downstream data source.

Parameters:
- N_CH, 4, number of requesting channels (IDs), 1..16
- FN_W, 32, function-code width
- DATA_W, 32, data word width
- DATA_SIZE, 8, words per response (`S2CIF_DATA_SIZE` equivalent), >=1
- TIMEOUT, 1024, max cycles from downstream accept to response last; 0 disables
- RET_TIMEOUT, 32'hFFFF_FFFF, ret value reported on timeout

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ch_req  in  N_CH  per-channel request level; held until matching ch_done
- ch_fn  in  N_CH*FN_W  per-channel function code; stable while ch_req high
- ch_done  out  N_CH  one-cycle pulse to the channel whose response completes
- up_valid  out  1  upstream data word valid
- up_ch  out  $clog2(N_CH) (min 1)  channel owning up_data
- up_idx  out  $clog2(DATA_SIZE) (min 1)  word index
- up_data  out  DATA_W  response word
- up_ret  out  32  ret code, valid with every up_valid
- up_ready  in  1  upstream accepts word
- dn_valid  out  1  downstream request valid
- dn_id  out  $clog2(N_CH) (min 1)  requesting ID
- dn_fn  out  FN_W  function code
- dn_ready  in  1  downstream accepts request
- dn_rsp_valid  in  1  response word valid
- dn_rsp_ret  in  32  ret code, sampled on first response word
- dn_rsp_data  in  DATA_W  response word
- dn_rsp_last  in  1  final response word

Behaviour:
- Reset (async, rst_n=0): state IDLE; all outputs 0; rr pointer 0 (channel 0 highest priority); buffer contents don't-care.
- FSM states and transitions:
  - IDLE: if any ch_req, grant the first requesting channel at or after rr pointer (wrap). Latch id and fn. Go to ISSUE next cycle. No ch_req: stay.
  - ISSUE: dn_valid=1, dn_id/dn_fn from latch. On dn_valid&&dn_ready: clear word count, start timer, go to COLLECT. No timeout while in ISSUE.
  - COLLECT:
    - Each dn_rsp_valid with count<DATA_SIZE writes buf[count] and increments count.
    - First word latches dn_rsp_ret.
    - Words beyond DATA_SIZE are dropped.
    - On dn_rsp_valid&&dn_rsp_last go to DELIVER. Unfilled buf entries are forced to 0 (short response).
    - If timer reaches TIMEOUT with no last: ret=RET_TIMEOUT, all words 0, go to DELIVER. Late response words are then ignored until next ISSUE.
  - DELIVER: up_valid=1, emits idx 0..DATA_SIZE-1 in order, advancing on up_ready. After the handshake of idx DATA_SIZE-1: ch_done[grant] pulses the next cycle, rr pointer becomes grant+1 mod N_CH, go to IDLE.
- Latency, minimum: request in IDLE → dn_valid 1 cycle later.
- Latency, response: dn last → first up_valid next cycle.
- Back-to-back requests: IDLE is visited for at least one cycle between transactions.
- Rules:
  - Only one transaction is outstanding at a time.
  - dn_rsp_valid outside COLLECT is ignored.
  - ch_req dropped mid-transaction does not abort; ch_done still pulses.
  - A granted channel that keeps ch_req high after ch_done is treated as a new request and loses priority to the other channels.
- Timer: counts cycles in COLLECT, saturating. The comparison uses >=TIMEOUT.
- Async reset mid-operation: immediate return to reset values. In-flight response is discarded. No ch_done.

Decomposition:
- Package s2c_pkg: state enum (IDLE/ISSUE/COLLECT/DELIVER), RET_OK=0, RET_TIMEOUT default, helper function for the rr next-grant search.
- One natural sub-module: s2c_rr_arb, a combinational round-robin grant given req vector and pointer. Buffer, FSM and timer stay in the top.

Test Plan:
- Single request: ch_req[1]=1, fn=0x10; dn_ready=1; 8 words 0xA0..0xA7 with last on 8th, ret=0 → dn_id=1, dn_fn=0x10; up emits idx0..7 = 0xA0..0xA7, up_ch=1, up_ret=0; ch_done[1] single pulse.
- Round-robin: ch_req=4'b1111 held, each served immediately → grant order 0,1,2,3,0; no channel served twice while another waits.
- Short/long response: last on 3rd word (0x1,0x2,0x3) → up_data 1,2,3,0,0,0,0,0. Then 10 words → only first 8 delivered, extra 2 dropped.
- Timeout: TIMEOUT=16, downstream silent after accept → at cycle 16 of COLLECT, up_ret=0xFFFFFFFF, all words 0, ch_done pulses. A late dn_rsp_valid is ignored.
- Backpressure: up_ready toggles 1,0,0,1,… and dn_ready low 5 cycles → dn_valid/dn_id/dn_fn stable while stalled; up_idx/up_data hold until accepted; no word lost or duplicated.
- Reset mid-COLLECT: rst_n low after 3 words → all outputs 0 immediately. After release, new request to ch2 served normally with rr pointer 0.
